// File: rtl/alu_pkg.sv
// Shared ALU op encodings, RV32I opcodes, issue-entry layout and buffer states
// for the ALU issue stage.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // The ALU shifts by the whole Y operand, so only shamt may be nonzero.
  function automatic logic [31:0] shamt_operand(input logic [4:0] shamt);
    return {27'd0, shamt};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decoder producing one ALU issue entry.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]  INSTR,
  input  logic [31:0]  PC,
  input  logic [31:0]  RS1_DATA,
  input  logic [31:0]  RS2_DATA,
  output issue_entry_t ENTRY
);

  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_u_s;
  logic [31:0] x_s;
  logic [31:0] y_s;
  logic [3:0]  op_s;
  logic        legal_s;

  assign opc_s   = INSTR[6:0];
  assign f3_s    = INSTR[14:12];
  assign f7_s    = INSTR[31:25];
  assign imm_i_s = {{20{INSTR[31]}}, INSTR[31:20]};
  assign imm_u_s = {INSTR[31:12], 12'd0};

  // Operand and operation selection by opcode and funct fields.
  always_comb begin
    x_s     = 32'd0;
    y_s     = 32'd0;
    op_s    = ALU_ADD;
    legal_s = 1'b0;
    case (opc_s)
      OPC_OP: begin
        x_s     = RS1_DATA;
        y_s     = RS2_DATA;
        legal_s = (f7_s == 7'h00) ||
                  ((f7_s == 7'h20) && ((f3_s == 3'd0) || (f3_s == 3'd5)));
        case (f3_s)
          3'd0: op_s = (f7_s == 7'h20) ? ALU_SUB : ALU_ADD;
          3'd1: begin
            op_s = ALU_SLL;
            y_s  = shamt_operand(RS2_DATA[4:0]);
          end
          3'd2: op_s = ALU_SLT;
          3'd3: op_s = ALU_SLTU;
          3'd4: op_s = ALU_XOR;
          3'd5: begin
            op_s = (f7_s == 7'h20) ? ALU_SRA : ALU_SRL;
            y_s  = shamt_operand(RS2_DATA[4:0]);
          end
          3'd6: op_s = ALU_OR;
          3'd7: op_s = ALU_AND;
          default: op_s = ALU_ADD;
        endcase
      end
      OPC_OP_IMM: begin
        x_s     = RS1_DATA;
        y_s     = imm_i_s;
        legal_s = 1'b1;
        case (f3_s)
          3'd0: op_s = ALU_ADD;
          3'd1: begin
            op_s    = ALU_SLL;
            y_s     = shamt_operand(INSTR[24:20]);
            legal_s = (f7_s == 7'h00);
          end
          3'd2: op_s = ALU_SLT;
          3'd3: op_s = ALU_SLTU;
          3'd4: op_s = ALU_XOR;
          3'd5: begin
            op_s    = (f7_s == 7'h20) ? ALU_SRA : ALU_SRL;
            y_s     = shamt_operand(INSTR[24:20]);
            legal_s = (f7_s == 7'h00) || (f7_s == 7'h20);
          end
          3'd6: op_s = ALU_OR;
          3'd7: op_s = ALU_AND;
          default: op_s = ALU_ADD;
        endcase
      end
      OPC_LUI: begin
        y_s     = imm_u_s;
        legal_s = 1'b1;
      end
      OPC_AUIPC: begin
        x_s     = PC;
        y_s     = imm_u_s;
        legal_s = 1'b1;
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Illegal instructions issue as a zeroed no-write entry that keeps rd.
  always_comb begin
    ENTRY.rd = INSTR[11:7];
    if (legal_s) begin
      ENTRY.x       = x_s;
      ENTRY.y       = y_s;
      ENTRY.op      = op_s;
      ENTRY.we      = (INSTR[11:7] != 5'd0);
      ENTRY.illegal = 1'b0;
    end else begin
      ENTRY.x       = 32'd0;
      ENTRY.y       = 32'd0;
      ENTRY.op      = ALU_ADD;
      ENTRY.we      = 1'b0;
      ENTRY.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU decode/issue stage with valid/ready on both sides.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with a registered IN_READY.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INSTR,
  input  logic [31:0] PC,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] X,
  output logic [31:0] Y,
  output logic [3:0]  OP,
  output logic [4:0]  RD,
  output logic        WE,
  output logic        ILLEGAL
);

  issue_entry_t dec_s;
  issue_entry_t out_q;
  buf_state_t   state_q;
  logic         out_valid_q;
  logic         accept_s;
  logic         issue_s;

  alu_op_decode u_decode (
    .INSTR    (INSTR),
    .PC       (PC),
    .RS1_DATA (RS1_DATA),
    .RS2_DATA (RS2_DATA),
    .ENTRY    (dec_s)
  );

  assign accept_s = IN_VALID && IN_READY;
  assign issue_s  = out_valid_q && OUT_READY;

`ifdef ALU_ISSUE_SKID_EN
  issue_entry_t skid_q;
  logic         in_ready_q;

  assign IN_READY = in_ready_q;

  // Output register plus one skid entry; IN_READY is computed for the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_q       <= '0;
      skid_q      <= '0;
    end else if (FLUSH) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            out_q       <= dec_s;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept_s && !issue_s) begin
            skid_q     <= dec_s;
            in_ready_q <= 1'b0;
            state_q    <= ST_TWO;
          end else if (!accept_s && issue_s) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end else if (accept_s && issue_s) begin
            out_q <= dec_s;
          end
        end
        ST_TWO: begin
          if (issue_s) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end
`else
  assign IN_READY = (state_q == ST_EMPTY) || OUT_READY;

  // Single pipeline register: a new entry may replace one leaving this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (FLUSH) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept_s) begin
      out_q       <= dec_s;
      out_valid_q <= 1'b1;
      state_q     <= ST_ONE;
    end else if (issue_s) begin
      out_valid_q <= 1'b0;
      state_q     <= ST_EMPTY;
    end else begin
      state_q <= state_q;
    end
  end
`endif

  assign OUT_VALID = out_valid_q;
  assign X         = out_q.x;
  assign Y         = out_q.y;
  assign OP        = out_q.op;
  assign RD        = out_q.rd;
  assign WE        = out_q.we;
  assign ILLEGAL   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with hand-computed
// expected entries, checked in order by a monitor as the DUT issues them.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INSTR;
  logic [31:0] PC;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] X;
  logic [31:0] Y;
  logic [3:0]  OP;
  logic [4:0]  RD;
  logic        WE;
  logic        ILLEGAL;

  int           n_checks = 0;
  int           n_fail   = 0;
  issue_entry_t exp_q[$];
  issue_entry_t cur_exp;

  alu_issue_stage dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .INSTR     (INSTR),
    .PC        (PC),
    .RS1_DATA  (RS1_DATA),
    .RS2_DATA  (RS2_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .X         (X),
    .Y         (Y),
    .OP        (OP),
    .RD        (RD),
    .WE        (WE),
    .ILLEGAL   (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  function automatic issue_entry_t mk(input logic [31:0] x, input logic [31:0] y,
                                      input logic [3:0] op, input logic [4:0] rd,
                                      input logic we, input logic il);
    issue_entry_t e;
    e.x = x; e.y = y; e.op = op; e.rd = rd; e.we = we; e.illegal = il;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pops expected entries on each issue; pushes the current expectation on each accept.
  task automatic monitor_loop();
    issue_entry_t got;
    issue_entry_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N || FLUSH) begin
        exp_q.delete();
      end else begin
        if (OUT_VALID && OUT_READY) begin
          got = mk(X, Y, OP, RD, WE, ILLEGAL);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got x=%08h y=%08h op=%0d rd=%0d we=%0b il=%0b, expected no issue",
                     X, Y, OP, RD, WE, ILLEGAL);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_fail++;
              $display("FAIL issue_entry: got x=%08h y=%08h op=%0d rd=%0d we=%0b il=%0b, expected x=%08h y=%08h op=%0d rd=%0d we=%0b il=%0b",
                       got.x, got.y, got.op, got.rd, got.we, got.illegal,
                       e.x, e.y, e.op, e.rd, e.we, e.illegal);
            end
          end
        end
        if (IN_VALID && IN_READY) exp_q.push_back(cur_exp);
      end
    end
  endtask

  // Drive one instruction from just after a rising edge until it is accepted.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input issue_entry_t e);
    logic rdy;
    int   waited;
    INSTR = ins; PC = pc; RS1_DATA = r1; RS2_DATA = r2; cur_exp = e;
    IN_VALID = 1'b1;
    waited = 0;
    forever begin
      @(negedge CLK);
      rdy = IN_READY;
      @(posedge CLK);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: instr 0x%08h not accepted within 50 cycles", ins);
        break;
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge CLK);
    #1;
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    INSTR = 32'd0; PC = 32'd0; RS1_DATA = 32'd0; RS2_DATA = 32'd0;
    cur_exp = '0;
    fork monitor_loop(); join_none

    #12;
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_x", X, 32'd0);
    check("rst_y", Y, 32'd0);
    check("rst_op", {28'd0, OP}, 32'd0);
    check("rst_rd", {27'd0, RD}, 32'd0);
    check("rst_we", {31'd0, WE}, 32'd0);
    check("rst_illegal", {31'd0, ILLEGAL}, 32'd0);
    check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Decode coverage, back to back at full throughput.
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, ALU_ADD, 5'd3, 1'b1, 1'b0));
    check("lat_out_valid", {31'd0, OUT_VALID}, 32'd1);
    check("lat_rd", {27'd0, RD}, 32'd3);
    send(32'h40208133, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, ALU_SUB, 5'd2, 1'b1, 1'b0));
    send(32'h40435293, 32'h0, 32'hFFFF0000, 32'd0, mk(32'hFFFF0000, 32'd4, ALU_SRA, 5'd5, 1'b1, 1'b0));
    send(32'h123450B7, 32'h0, 32'hDEAD0000, 32'd1, mk(32'd0, 32'h12345000, ALU_ADD, 5'd1, 1'b1, 1'b0));
    send(32'h00001217, 32'h100, 32'd9, 32'd9, mk(32'h100, 32'h1000, ALU_ADD, 5'd4, 1'b1, 1'b0));
    send(32'h0000A083, 32'h0, 32'd3, 32'd4, mk(32'd0, 32'd0, ALU_ADD, 5'd1, 1'b0, 1'b1));
    send(32'h40331293, 32'h0, 32'd3, 32'd4, mk(32'd0, 32'd0, ALU_ADD, 5'd5, 1'b0, 1'b1));
    send(32'hFFF00393, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'hFFFFFFFF, ALU_ADD, 5'd7, 1'b1, 1'b0));
    send(32'h00209033, 32'h0, 32'h80000001, 32'h23, mk(32'h80000001, 32'd3, ALU_SLL, 5'd0, 1'b0, 1'b0));
    send(32'h0020B433, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, ALU_SLTU, 5'd8, 1'b1, 1'b0));
    send(32'h4020F1B3, 32'h0, 32'd1, 32'd2, mk(32'd0, 32'd0, ALU_ADD, 5'd3, 1'b0, 1'b1));
    drain("drain_decode");

    // Backpressure with three distinct instructions.
    OUT_READY = 1'b0;
    send(32'h002081B3, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, ALU_ADD, 5'd3, 1'b1, 1'b0));
`ifdef ALU_ISSUE_SKID_EN
    check("bp_ready_after_1st", {31'd0, IN_READY}, 32'd1);
    send(32'h0020C233, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, ALU_XOR, 5'd4, 1'b1, 1'b0));
    check("bp_ready_after_2nd", {31'd0, IN_READY}, 32'd0);
`else
    check("bp_ready_after_1st", {31'd0, IN_READY}, 32'd0);
`endif
    @(posedge CLK); #1;
    check("bp_hold_valid", {31'd0, OUT_VALID}, 32'd1);
    check("bp_hold_x", X, 32'd1);
    fork
      begin
        repeat (2) @(posedge CLK);
        #2 OUT_READY = 1'b1;
      end
    join_none
`ifndef ALU_ISSUE_SKID_EN
    send(32'h0020C233, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, ALU_XOR, 5'd4, 1'b1, 1'b0));
`endif
    send(32'h0020E2B3, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, ALU_OR, 5'd5, 1'b1, 1'b0));
    drain("drain_backpressure");

    // Flush while full, together with a new input.
    OUT_READY = 1'b0;
    send(32'h002081B3, 32'h0, 32'd11, 32'd22, mk(32'd11, 32'd22, ALU_ADD, 5'd3, 1'b1, 1'b0));
`ifdef ALU_ISSUE_SKID_EN
    send(32'h0020C233, 32'h0, 32'd11, 32'd22, mk(32'd11, 32'd22, ALU_XOR, 5'd4, 1'b1, 1'b0));
`endif
    INSTR = 32'h0020E2B3; IN_VALID = 1'b1; FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    check("flush_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("flush_in_ready", {31'd0, IN_READY}, 32'd1);
    OUT_READY = 1'b1;
    drain("drain_flush");

    // Asynchronous reset in the middle of a stalled transfer.
    OUT_READY = 1'b0;
    send(32'h0020B433, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, ALU_SLTU, 5'd8, 1'b1, 1'b0));
    #1 RST_N = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("arst_x", X, 32'd0);
    check("arst_op", {28'd0, OP}, 32'd0);
    check("arst_in_ready", {31'd0, IN_READY}, 32'd1);
    @(posedge CLK); #2;
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, ALU_ADD, 5'd3, 1'b1, 1'b0));
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
